// File: rtl/dl_sequencer.sv
// dl_sequencer
//   Sequences ROM/RAM download traffic from the HPS ioctl stream into the
//   system's target memories. It keeps the system core in reset for the whole
//   download and for RST_HOLD cycles afterwards. It decodes ioctl_index into a
//   one-hot target select. It buffers exactly one write and backpressures the
//   HPS (ioctl_wait) until the selected target acknowledges that write.
//
// Ports
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   ioctl_download            download in progress (HPS)
//   ioctl_wr                  one-cycle write strobe (HPS)
//   ioctl_addr/dout/index     byte address, byte data, target index (HPS)
//   ioctl_wait                backpressure to HPS (registered buffer-full flag)
//   dn_addr/dn_data/dn_sel    buffered write towards the target memories
//   dn_wr                     write request, held until dn_ack
//   dn_ack                    target takes the write this cycle
//   sys_reset                 active-high reset to the system core
//   dl_done                   one-cycle pulse when a download has drained
//   dl_count                  writes accepted in the current/last download
//   dl_err                    sticky: a write was dropped in current/last download
//   dbg_state                 current FSM state (HOLD=0, RUN=1, LOAD=2, FLUSH=3)
//
// Handshake: a buffered write is offered with dn_wr=1 and stays unchanged
// until a cycle in which dn_ack=1. That cycle is the transfer. dn_ack has no
// meaning while dn_wr=0. In the transfer cycle a new ioctl write may refill
// the buffer (back-to-back reload), so dn_wr then stays high for the next write.
module dl_sequencer #(
  parameter int ADDR_W      = 14,
  parameter int NUM_TARGETS = 4,
  parameter int RST_HOLD    = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [7:0]             ioctl_index,
  output logic                   ioctl_wait,
  output logic [ADDR_W-1:0]      dn_addr,
  output logic [7:0]             dn_data,
  output logic                   dn_wr,
  output logic [NUM_TARGETS-1:0] dn_sel,
  input  logic                   dn_ack,
  output logic                   sys_reset,
  output logic                   dl_done,
  output logic [24:0]            dl_count,
  output logic                   dl_err,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, LOAD = 2'd2, FLUSH = 2'd3} state_t;

  localparam int          CNT_W      = $clog2(RST_HOLD + 1);
  localparam logic [24:0] ADDR_LIMIT = 25'(1) << ADDR_W;
  localparam logic [7:0]  IDX_LIMIT  = 8'(NUM_TARGETS);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;

  logic                   wr_legal;
  logic                   wr_take;
  logic                   do_load;
  logic                   do_drop;
  logic                   do_release;
  logic [NUM_TARGETS-1:0] sel_onehot;

  always_comb begin
    wr_legal   = (ioctl_index < IDX_LIMIT) && (ioctl_addr < ADDR_LIMIT);
    wr_take    = (state == LOAD) && ioctl_wr;
    // The buffer can take a write when it is empty or is being drained now.
    do_load    = wr_take && wr_legal && (!dn_wr || dn_ack);
    do_drop    = wr_take && !(wr_legal && (!dn_wr || dn_ack));
    do_release = dn_wr && dn_ack && !do_load;
    sel_onehot = NUM_TARGETS'(1) << ioctl_index;
  end

  assign dbg_state = state;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HOLD;
      hold_cnt   <= CNT_W'(RST_HOLD);
      sys_reset  <= 1'b1;
      dn_wr      <= 1'b0;
      ioctl_wait <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_sel     <= '0;
      dl_done    <= 1'b0;
      dl_count   <= '0;
      dl_err     <= 1'b0;
    end else begin
      dl_done <= 1'b0;

      // Single write buffer. dn_addr/dn_data keep their last values on release.
      if (do_load) begin
        dn_wr      <= 1'b1;
        ioctl_wait <= 1'b1;
        dn_addr    <= ioctl_addr[ADDR_W-1:0];
        dn_data    <= ioctl_dout;
        dn_sel     <= sel_onehot;
        if (dl_count != '1) dl_count <= dl_count + 25'd1;
      end else if (do_release) begin
        dn_wr      <= 1'b0;
        ioctl_wait <= 1'b0;
        dn_sel     <= '0;
      end

      if (do_drop) dl_err <= 1'b1;

      // Statistics are cleared on every entry into LOAD. Writes are only taken
      // in LOAD, so the clear never collides with an increment or a drop.
      case (state)
        HOLD: begin
          sys_reset <= 1'b1;
          if (ioctl_download) begin
            state    <= LOAD;
            dl_count <= '0;
            dl_err   <= 1'b0;
          end else if (hold_cnt == '0) begin
            state     <= RUN;
            sys_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RUN: begin
          // HOLD only hands over to RUN while ioctl_download=0, so a 1 here
          // is always a fresh rising edge.
          if (ioctl_download) begin
            state     <= LOAD;
            sys_reset <= 1'b1;
            dl_count  <= '0;
            dl_err    <= 1'b0;
          end
        end
        LOAD: begin
          if (!ioctl_download) state <= FLUSH;
        end
        FLUSH: begin
          // Wait for the pending write to drain. There is no timeout.
          if (!dn_wr) begin
            state    <= HOLD;
            hold_cnt <= CNT_W'(RST_HOLD);
            dl_done  <= 1'b1;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_dl_sequencer.sv
module tb_dl_sequencer;

  localparam int ADDR_W   = 14;
  localparam int NT       = 4;
  localparam int RST_HOLD = 16;
  localparam int W        = ADDR_W + 8 + NT;

  logic              clk_sys;
  logic              reset_n;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic [NT-1:0]     dn_sel;
  logic              dn_ack;
  logic              sys_reset;
  logic              dl_done;
  logic [24:0]       dl_count;
  logic              dl_err;
  logic [1:0]        dbg_state;

  dl_sequencer #(.ADDR_W(ADDR_W), .NUM_TARGETS(NT), .RST_HOLD(RST_HOLD)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_sel         (dn_sel),
    .dn_ack         (dn_ack),
    .sys_reset      (sys_reset),
    .dl_done        (dl_done),
    .dl_count       (dl_count),
    .dl_err         (dl_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [W-1:0] exp_q[$];
  int         exp_count = 0;
  bit         exp_err   = 1'b0;
  bit         mon_en    = 1'b0;
  int         ack_fixed = -1;
  int         ack_once  = -1;
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Drive point: shortly after the active edge.
  task automatic sync();
    @(posedge clk_sys);
    #2;
  endtask

  // ---------------- target (ack responder) ----------------
  // Each new write gets an ack delay. ack_once overrides one write and
  // ack_fixed overrides all writes. Otherwise the delay is random 0..2.
  // While dn_wr=0 the ack line carries random junk, which the DUT must ignore.
  initial begin : ack_proc
    int delay;
    bit new_w;
    dn_ack = 1'b0;
    new_w  = 1'b1;
    delay  = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!reset_n) begin
        dn_ack = 1'b0;
        new_w  = 1'b1;
      end else begin
        if (dn_ack || !dn_wr) new_w = 1'b1;
        if (dn_wr) begin
          if (new_w) begin
            if (ack_once >= 0) begin
              delay    = ack_once;
              ack_once = -1;
            end else if (ack_fixed >= 0) begin
              delay = ack_fixed;
            end else begin
              delay = $urandom_range(0, 2);
            end
            new_w = 1'b0;
          end
          if (delay == 0) dn_ack = 1'b1;
          else begin
            delay--;
            dn_ack = 1'b0;
          end
        end else begin
          dn_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- monitor ----------------
  // The buffer is full exactly when the model holds an undelivered write.
  always @(negedge clk_sys) begin
    if (reset_n && mon_en) begin
      check("ioctl_wait", 32'(ioctl_wait), 32'(exp_q.size() != 0));
      check("dn_wr", 32'(dn_wr), 32'(exp_q.size() != 0));
      if (!dn_wr) check("dn_sel_idle", 32'(dn_sel), 32'd0);
      if (dn_wr && dn_ack && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("dn_write", 32'({dn_addr, dn_data, dn_sel}), 32'(mon_e));
      end
      if (dl_done) begin
        check("dl_count", 32'(dl_count), 32'(exp_count));
        check("dl_err", 32'(dl_err), 32'(exp_err));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Reference rules: a write is taken only if index < NT and addr < 2**ADDR_W
  // and the buffer is empty or acked in the same cycle. Otherwise it sets
  // the error flag. Called at a drive point; returns at a drive point.
  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr,
                         input logic [7:0] data, input bit no_wait);
    int n;
    bit legal;
    bit full;
    logic [NT-1:0] sel;
    n = 0;
    if (!no_wait) begin
      while (exp_q.size() != 0 && !dn_ack && n < 60) begin
        sync();
        n++;
      end
      if (n >= 60) bound_fail("wr_wait");
    end
    legal = (idx < NT) && (addr < 25'(2 ** ADDR_W));
    full  = (exp_q.size() != 0) && !dn_ack;
    sel   = '0;
    if (legal) sel[idx[1:0]] = 1'b1;
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    @(posedge clk_sys);
    if (legal && !full) begin
      exp_q.push_back({addr[ADDR_W-1:0], data, sel});
      exp_count++;
    end else begin
      exp_err = 1'b1;
    end
    #2;
    ioctl_wr    = 1'b0;
    ioctl_addr  = 25'($urandom);
    ioctl_dout  = 8'($urandom);
    ioctl_index = 8'($urandom);
  endtask

  task automatic begin_dl();
    sync();
    ioctl_download = 1'b1;
    exp_count      = 0;
    exp_err        = 1'b0;
    sync();
    sync();
    check("sys_reset_load", 32'(sys_reset), 32'd1);
  endtask

  // Count how long sys_reset stays high, sampling after each later edge.
  task automatic count_hold(input string name);
    int h;
    bit done;
    h    = 0;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (sys_reset) h++;
      else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) bound_fail(name);
    else check(name, 32'(h), 32'(RST_HOLD));
  endtask

  task automatic end_dl();
    int n;
    ioctl_download = 1'b0;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!dl_done && n < 300);
    if (!dl_done) bound_fail("dl_done_wait");
    else begin
      @(negedge clk_sys);
      check("dl_done_pulse", 32'(dl_done), 32'd0);
      // The sample just taken is the first of the RST_HOLD hold cycles.
      if (sys_reset) begin
        int h;
        h = 1;
        for (int i = 0; i < 100 && sys_reset; i++) begin
          @(negedge clk_sys);
          if (sys_reset) h++;
        end
        check("hold_after_dl", 32'(h), 32'(RST_HOLD));
      end else begin
        check("hold_after_dl", 32'd0, 32'(RST_HOLD));
      end
    end
    sync();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sys_reset"}, 32'(sys_reset), 32'd1);
    check({tag, "_dn_wr"}, 32'(dn_wr), 32'd0);
    check({tag, "_ioctl_wait"}, 32'(ioctl_wait), 32'd0);
    check({tag, "_dn_addr"}, 32'(dn_addr), 32'd0);
    check({tag, "_dn_data"}, 32'(dn_data), 32'd0);
    check({tag, "_dn_sel"}, 32'(dn_sel), 32'd0);
    check({tag, "_dl_done"}, 32'(dl_done), 32'd0);
    check({tag, "_dl_count"}, 32'(dl_count), 32'd0);
    check({tag, "_dl_err"}, 32'(dl_err), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    repeat (3) @(posedge clk_sys);
    #2;
    check_reset_vals("rst0");

    // Reset release with no download: hold for RST_HOLD cycles, then run.
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk_sys);
    count_hold("hold_after_reset");
    sync();

    // Index 1, four bytes, target acks one cycle after each request.
    ack_fixed = 1;
    begin_dl();
    for (int i = 0; i < 4; i++) wr_byte(8'd1, 25'(i), 8'(8'hA0 + i), 1'b0);
    end_dl();
    ack_fixed = -1;
    check("dl_count_basic", 32'(dl_count), 32'd4);

    // First write stalled five cycles by the target.
    ack_once = 5;
    begin_dl();
    wr_byte(8'd2, 25'h0123, 8'h5C, 1'b0);
    begin
      int n;
      n = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk_sys);
        if (!ioctl_wait) break;
        n++;
        check("stall_addr", 32'(dn_addr), 32'h0123);
        check("stall_data", 32'(dn_data), 32'h5C);
      end
      check("stall_wait_cycles", 32'(n), 32'd6);
    end
    sync();
    end_dl();

    // Out-of-range index and address are dropped.
    begin_dl();
    wr_byte(8'd4, 25'h0010, 8'h33, 1'b0);
    wr_byte(8'd0, 25'h4000, 8'h44, 1'b0);
    wr_byte(8'd3, 25'h3FFF, 8'h55, 1'b0);
    end_dl();
    check("dl_err_invalid", 32'(dl_err), 32'd1);
    check("dl_count_invalid", 32'(dl_count), 32'd1);

    // Second write while the buffer is full and not acked is dropped.
    ack_once = 6;
    begin_dl();
    wr_byte(8'd0, 25'h0020, 8'h11, 1'b0);
    wr_byte(8'd1, 25'h0021, 8'h22, 1'b1);
    end_dl();
    check("dl_err_overrun", 32'(dl_err), 32'd1);

    // Writes outside a download are ignored.
    ioctl_wr    = 1'b1;
    ioctl_index = 8'd0;
    ioctl_addr  = 25'h0005;
    sync();
    ioctl_wr = 1'b0;
    repeat (3) sync();
    check("count_outside_load", 32'(dl_count), 32'(exp_count));
    check("err_outside_load", 32'(dl_err), 32'(exp_err));

    // Randomized downloads against the reference rules.
    for (int d = 0; d < 6; d++) begin
      int nw;
      begin_dl();
      nw = $urandom_range(3, 20);
      for (int k = 0; k < nw; k++) begin
        logic [7:0]  idx;
        logic [24:0] addr;
        idx  = 8'($urandom_range(0, NT - 1));
        addr = 25'($urandom_range(0, 2 ** ADDR_W - 1));
        if ($urandom_range(0, 7) == 0) idx = 8'($urandom_range(NT, 255));
        if ($urandom_range(0, 7) == 0) addr = 25'($urandom_range(2 ** ADDR_W, 32'h1FF_FFFF));
        wr_byte(idx, addr, 8'($urandom), 1'b0);
        repeat ($urandom_range(0, 2)) sync();
      end
      end_dl();
    end

    // Download raised mid-HOLD, then asynchronous reset mid-LOAD.
    mon_en  = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("rst1");
    sync();
    sync();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (8) @(posedge clk_sys);
    #2;
    check("sys_reset_hold8", 32'(sys_reset), 32'd1);
    ioctl_download = 1'b1;
    exp_count      = 0;
    exp_err        = 1'b0;
    sync();
    check("sys_reset_abort", 32'(sys_reset), 32'd1);
    ack_once = 20;
    wr_byte(8'd2, 25'h0055, 8'h77, 1'b0);
    check("abort_load_write", 32'(dn_wr), 32'd1);
    sync();
    check("sys_reset_abort_load", 32'(sys_reset), 32'd1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("rst2");
    ioctl_download = 1'b0;
    sync();
    sync();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk_sys);
    count_hold("hold_after_reset2");
    repeat (3) sync();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
